dtc_link_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single write port of the InputDTC stub memory among N_LINKS DTC input links.

---
 rtl/dtc_link_arbiter.sv | 95 +++++++++
 tb/tb_dtc_link_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dtc_link_arbiter.sv
// dtc_link_arbiter: round-robin arbiter sharing the InputDTC stub memory write port among N_LINKS links
//  clk, reset_n (async, active-low)
//  in_valid/in_data/in_ready : per-link stub handshake, in_ready is a one-hot combinational grant
//  bx_start/bx_in            : new-BX pulse and BX number
//  mem_we/mem_addr/mem_din   : registered memory write, mem_addr = {bx page, entry}
//  nent_valid/nent           : entry count of the BX that just closed
//  ovf                       : sticky, a stub was dropped on a full page
//  Option DTC_ARB_LINK_TAG_EN: mem_din = {link index, stub}; otherwise mem_din = stub only.
module dtc_link_arbiter #(
  parameter int N_LINKS = 4,
  parameter int STUB_W  = 36,
  parameter int BX_W    = 3,
  parameter int ADDR_W  = 6,
  parameter int LINK_W  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_LINKS-1:0]          in_valid,
  input  logic [N_LINKS*STUB_W-1:0]   in_data,
  output logic [N_LINKS-1:0]          in_ready,
  input  logic                        bx_start,
  input  logic [BX_W-1:0]             bx_in,
  output logic                        mem_we,
  output logic [BX_W+ADDR_W-1:0]      mem_addr,
`ifdef DTC_ARB_LINK_TAG_EN
  output logic [STUB_W+LINK_W-1:0]    mem_din,
`else
  output logic [STUB_W-1:0]           mem_din,
`endif
  output logic                        nent_valid,
  output logic [ADDR_W:0]             nent,
  output logic                        ovf
);
  typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  state_t state;
  logic [LINK_W-1:0] rr, gidx;
  logic [BX_W-1:0] bx_cur, page;
  logic [ADDR_W:0] wr_cnt, cnt_base, cnt_nxt;
  logic fire, new_bx, wr;
  logic [STUB_W-1:0] stub;
  // first valid link at or after the rr pointer, wrapping; nothing granted while IDLE
  always_comb begin
    int j;
    j = 0;
    fire = 1'b0;
    gidx = '0;
    for (int k = 0; k < N_LINKS; k++) begin
      j = (int'(rr) + k) % N_LINKS;
      if (!fire && in_valid[j] && state != IDLE) begin
        fire = 1'b1;
        gidx = LINK_W'(j);
      end
    end
  end
  assign in_ready = fire ? {{(N_LINKS-1){1'b0}}, 1'b1} << gidx : '0;
  assign stub = in_data[int'(gidx)*STUB_W +: STUB_W];
  // a grant coinciding with bx_start lands at entry 0 of the new page, even out of FULL
  assign new_bx = bx_start && state != IDLE;
  assign wr = fire && (state == RUN || bx_start);
  assign cnt_base = new_bx ? '0 : wr_cnt;
  assign cnt_nxt = cnt_base + {{ADDR_W{1'b0}}, wr};
  assign page = new_bx ? bx_in : bx_cur;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rr <= '0;
      bx_cur <= '0;
      wr_cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_din <= '0;
      nent_valid <= 1'b0;
      nent <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state == IDLE ? (bx_start ? RUN : IDLE) : (cnt_nxt == DEPTH ? FULL : RUN);
      mem_we <= wr;
      nent_valid <= new_bx;
      wr_cnt <= cnt_nxt;
      if (new_bx) nent <= wr_cnt;
      if (bx_start) bx_cur <= bx_in;
      if (fire) rr <= gidx == LINK_W'(N_LINKS-1) ? '0 : gidx + 1'b1;
      if (fire && !wr) ovf <= 1'b1;
      if (wr) begin
        mem_addr <= {page, cnt_base[ADDR_W-1:0]};
`ifdef DTC_ARB_LINK_TAG_EN
        mem_din <= {gidx, stub};
`else
        mem_din <= stub;
`endif
      end
    end
  end
endmodule

// File: tb/tb_dtc_link_arbiter.sv
// tb_dtc_link_arbiter: directed-vector self-checking bench for dtc_link_arbiter
module tb_dtc_link_arbiter;
`ifdef DTC_ARB_LINK_TAG_EN
  localparam int DIN_W = 38;
`else
  localparam int DIN_W = 36;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] in_valid = '0;
  logic [143:0] in_data;
  logic [3:0] in_ready;
  logic bx_start = 1'b0;
  logic [2:0] bx_in = '0;
  logic mem_we;
  logic [8:0] mem_addr;
  logic [DIN_W-1:0] mem_din;
  logic nent_valid;
  logic [6:0] nent;
  logic ovf;
  int n_chk = 0;
  int n_fail = 0;
  dtc_link_arbiter dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .bx_start(bx_start), .bx_in(bx_in), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .nent_valid(nent_valid), .nent(nent), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [35:0] stub(input int l);
    return {32'hC0DE0000 + 32'(l), 4'(l)};
  endfunction
  function automatic logic [63:0] exp_din(input int l);
`ifdef DTC_ARB_LINK_TAG_EN
    return 64'({2'(l), stub(l)});
`else
    return 64'(stub(l));
`endif
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic [3:0] v, input logic bs, input logic [2:0] bx, input logic [3:0] rdy);
    in_valid = v;
    bx_start = bs;
    bx_in = bx;
    #1 check("in_ready", 64'(in_ready), 64'(rdy));
    @(posedge clk);
    #1 bx_start = 1'b0;
    in_valid = '0;
  endtask
  task automatic chk_wr(input string tag, input logic [2:0] bx, input int a, input int l);
    check({tag, "_we"}, 64'(mem_we), 64'd1);
    check({tag, "_addr"}, 64'(mem_addr), 64'({bx, 6'(a)}));
    check({tag, "_din"}, 64'(mem_din), exp_din(l));
  endtask
  initial begin
    for (int i = 0; i < 4; i++) in_data[i*36 +: 36] = stub(i);
    #12 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_we", 64'(mem_we), 0);
    check("rst_addr", 64'(mem_addr), 0);
    check("rst_din", 64'(mem_din), 0);
    check("rst_nv", 64'(nent_valid), 0);
    check("rst_nent", 64'(nent), 0);
    check("rst_ovf", 64'(ovf), 0);
    // IDLE: links stall, first bx_start gives no count
    step(4'hF, 1'b1, 3'd2, 4'b0000);
    check("idle_nv", 64'(nent_valid), 0);
    check("idle_we", 64'(mem_we), 0);
    for (int k = 0; k < 8; k++) begin
      step(4'hF, 1'b0, 3'd0, 4'(1 << (k % 4)));
      chk_wr("rr", 3'd2, k, k % 4);
    end
    for (int k = 0; k < 3; k++) begin
      step(4'b0100, 1'b0, 3'd0, 4'b0100);
      chk_wr("solo", 3'd2, 8 + k, 2);
    end
    step(4'hF, 1'b0, 3'd0, 4'b1000);
    chk_wr("after_solo", 3'd2, 11, 3);
`ifdef DTC_ARB_LINK_TAG_EN
    check("tag", 64'(mem_din[36 +: 2]), 64'd3);
`endif
    step(4'h0, 1'b1, 3'd5, 4'b0000);
    check("bx5_nv", 64'(nent_valid), 1);
    check("bx5_nent", 64'(nent), 12);
    check("bx5_we", 64'(mem_we), 0);
    for (int k = 0; k < 64; k++) begin
      step(4'hF, 1'b0, 3'd0, 4'(1 << (k % 4)));
      if (k == 0) check("nv_pulse", 64'(nent_valid), 0);
      chk_wr("fill", 3'd5, k, k % 4);
    end
    check("ovf_pre", 64'(ovf), 0);
    for (int k = 0; k < 3; k++) begin
      step(4'hF, 1'b0, 3'd0, 4'(1 << k));
      check("drop_we", 64'(mem_we), 0);
      check("drop_ovf", 64'(ovf), 1);
    end
    step(4'b0010, 1'b1, 3'd6, 4'b0010);
    check("full_bx_nv", 64'(nent_valid), 1);
    check("full_bx_nent", 64'(nent), 64);
    chk_wr("full_bx", 3'd6, 0, 1);
    step(4'b0010, 1'b0, 3'd0, 4'b0010);
    chk_wr("bx6_next", 3'd6, 1, 1);
    step(4'b0001, 1'b1, 3'd6, 4'b0001);
    check("same_bx_nent", 64'(nent), 2);
    check("same_bx_nv", 64'(nent_valid), 1);
    chk_wr("same_bx", 3'd6, 0, 0);
    check("ovf_sticky", 64'(ovf), 1);
    for (int k = 0; k < 10; k++) begin
      step(4'hF, 1'b0, 3'd0, 4'(1 << ((k + 1) % 4)));
      chk_wr("pre_rst", 3'd6, k + 1, (k + 1) % 4);
    end
    in_valid = 4'hF;
    #2 reset_n = 1'b0;
    #1;
    check("arst_we", 64'(mem_we), 0);
    check("arst_addr", 64'(mem_addr), 0);
    check("arst_din", 64'(mem_din), 0);
    check("arst_ovf", 64'(ovf), 0);
    check("arst_nent", 64'(nent), 0);
    check("arst_rdy", 64'(in_ready), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(4'h0, 1'b1, 3'd3, 4'b0000);
    check("post_rst_nv", 64'(nent_valid), 0);
    step(4'hF, 1'b0, 3'd0, 4'b0001);
    chk_wr("post_rst", 3'd3, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
